// File: rtl/spi_master_fifo.sv
// SPI master with a bus-programmed TX FIFO, carrying a per-frame data/command bit for LCD controllers.
// Register map: 0x00 TXDATA/RXDATA, 0x04 CTRL, 0x08 STATUS.
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        lcd_dc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT_A, SHIFT_B, TRAIL} state_t;

    state_t                state, state_nx;
    logic [DATA_W:0]       mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, level;
    logic                  empty, full, busy, push, pop, ovf, ovf_evt;
    logic                  tx_wr, ctrl_wr, stat_rd, tick, last_bit, enter_a, enter_b;
    logic [DIV_WIDTH-1:0]  div, cnt;
    logic                  cpol, cpha;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_W-1:0]     sh, rx_sh, rxdata;
    logic [31:0]           ctrl_rd, stat_rd_val;
    logic                  unused_bits;

    assign unused_bits = ^{address_in, write_value_in};
    assign ready_out   = sel_in;

    assign tx_wr   = sel_in && (|write_mask_in) && address_in[7:0] == 8'h00;
    assign ctrl_wr = sel_in && (|write_mask_in) && address_in[7:0] == 8'h04 && !busy;
    assign stat_rd = sel_in && read_in && address_in[7:0] == 8'h08;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == FIFO_DEPTH[AW:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = tx_wr && (!full || pop);
    assign ovf_evt = tx_wr && full && !pop;
    assign busy    = (state != IDLE) || !empty;

    assign tick     = (cnt == div);
    assign last_bit = (bit_cnt == BW'(DATA_W - 1));
    assign enter_a  = tick && (state == LEAD || (state == SHIFT_B && !last_bit));
    assign enter_b  = tick && state == SHIFT_A;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {write_value_in[16], write_value_in[DATA_W-1:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE:    if (!empty) begin state_nx = LEAD; pop = 1'b1; end
            LEAD:    if (tick) state_nx = SHIFT_A;
            SHIFT_A: if (tick) state_nx = SHIFT_B;
            SHIFT_B: if (tick) state_nx = last_bit ? TRAIL : SHIFT_A;
            TRAIL:   if (tick) begin
                         if (!empty) begin state_nx = LEAD; pop = 1'b1; end
                         else state_nx = IDLE;
                     end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        spi_clk  = (state == SHIFT_A) ? ~cpol : cpol;
        spi_cs_n = (state == IDLE);
        spi_mosi = (state == IDLE) ? 1'b0 : sh[DATA_W-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            div     <= '0;
            cpol    <= 1'b0;
            cpha    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            rx_sh   <= '0;
            rxdata  <= '0;
            lcd_dc  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Overflow in the read cycle wins over the read-to-clear.
            ovf <= (ovf && !stat_rd) || ovf_evt;
            if (ctrl_wr) begin
                div  <= write_value_in[DIV_WIDTH-1:0];
                cpol <= write_value_in[16];
                cpha <= write_value_in[17];
            end
            if (state_nx != state || state == IDLE) cnt <= '0;
            else                                    cnt <= cnt + 1'b1;
            if (pop) begin
                {lcd_dc, sh} <= mem[rd_ptr[AW-1:0]];
                bit_cnt      <= '0;
            end else begin
                if (state == SHIFT_B && tick) bit_cnt <= bit_cnt + 1'b1;
                if ((enter_a && !cpha) || (enter_b && cpha))
                    rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
                // With cpha=1 the MSB is already on MOSI for the first leading edge.
                if ((enter_b && !cpha) || (enter_a && cpha && state == SHIFT_B))
                    sh <= {sh[DATA_W-2:0], 1'b0};
            end
            if (state == TRAIL && tick) rxdata <= rx_sh;
        end
    end

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[DIV_WIDTH-1:0]   = div;
        ctrl_rd[16]              = cpol;
        ctrl_rd[17]              = cpha;
        stat_rd_val              = '0;
        stat_rd_val[15:8]        = 8'(level);
        stat_rd_val[3:0]         = {ovf, full, empty, busy};
        case (address_in[7:0])
            8'h00:   read_value_out = 32'(rxdata);
            8'h04:   read_value_out = ctrl_rd;
            8'h08:   read_value_out = stat_rd_val;
            default: read_value_out = '0;
        endcase
    end

endmodule

// File: doc/spi_master_fifo.md
SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits (8 or 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 8, clock-divider field width.
REQ-004 SHALL have one clock and one reset: clock `clk` (input, 1, all logic on rising edge); reset `reset_n` (input, 1, asynchronous, active-low).
REQ-005 SHALL have port `address_in` (input, 32): bus address; only bits [7:0] decoded as offset.
REQ-006 SHALL have port `sel_in` (input, 1): bus select.
REQ-007 SHALL have port `read_in` (input, 1): read strobe.
REQ-008 SHALL have port `write_mask_in` (input, 4): write byte mask; a write is any nonzero mask.
REQ-009 SHALL have port `write_value_in` (input, 32): write data.
REQ-010 SHALL have port `read_value_out` (output, 32): read data, combinational.
REQ-011 SHALL have port `ready_out` (output, 1): equals `sel_in`.
REQ-012 SHALL have SPI port `spi_clk` (output, 1).
REQ-013 SHALL have SPI port `spi_mosi` (output, 1).
REQ-014 SHALL have SPI port `spi_miso` (input, 1).
REQ-015 SHALL have SPI port `spi_cs_n` (output, 1).
REQ-016 SHALL have port `lcd_dc` (output, 1): data/command, taken from the active frame.

Function
REQ-017 Register map: 0x00 TXDATA (W) / RXDATA (R); 0x04 CTRL (R/W); 0x08 STATUS (R).
REQ-018 TXDATA write SHALL push {write_value_in[16], write_value_in[DATA_W-1:0]} (DC bit, data) into the TX FIFO once per write cycle.
REQ-019 A push when the FIFO is full SHALL be dropped and SHALL set sticky STATUS.ovf.
REQ-020 CTRL fields: [DIV_WIDTH-1:0] div, [16] cpol, [17] cpha. The reset value of every CTRL field is 0.
REQ-021 A CTRL write while busy SHALL be ignored.
REQ-022 STATUS fields: [0] busy, [1] empty, [2] full, [3] ovf, [15:8] FIFO level.
REQ-023 A STATUS read SHALL clear ovf on the following cycle; a simultaneous overflow SHALL keep ovf at 1.
REQ-024 A simultaneous push and pop on a full FIFO SHALL be accepted, with the level unchanged.
REQ-025 Half-period: (div+1) clk cycles. div=0 gives spi_clk = clk/2.
REQ-026 FSM states: IDLE, LEAD, SHIFT_A, SHIFT_B, TRAIL.
REQ-027 IDLE->LEAD when the FIFO is non-empty: the FIFO pops one entry, the entry is loaded into the shift register and DC register, and spi_cs_n drops.
REQ-028 LEAD lasts one half-period; when cpha=0, MSB SHALL be driven on MOSI during LEAD.
REQ-029 SHIFT_A is the leading-edge half: spi_clk=~cpol. With cpha=0, MISO is sampled at its entry; with cpha=1, the next bit is shifted out at its entry.
REQ-030 SHIFT_B is the trailing-edge half: spi_clk=cpol. With cpha=0, the next bit is shifted out; with cpha=1, MISO is sampled.
REQ-031 A bit counter SHALL count DATA_W SHIFT_A/SHIFT_B pairs, then go to TRAIL.
REQ-032 TRAIL lasts one half-period; spi_clk=cpol. Then:
- FIFO non-empty: pop, reload, go to LEAD with spi_cs_n held low (back-to-back frames, no CS gap).
- FIFO empty: go to IDLE and spi_cs_n returns high.
REQ-033 Transmission SHALL be MSB-first. The received word SHALL be copied to RXDATA at the end of TRAIL.
REQ-034 busy SHALL be 1 in any state other than IDLE, and also in IDLE while the FIFO is non-empty.
REQ-035 lcd_dc SHALL change only at frame load, never mid-frame.
REQ-036 Reads of undefined offsets SHALL return 0; writes to undefined offsets SHALL be ignored.

Reset
REQ-037 Asserting reset_n low SHALL at once force: IDLE, FIFO empty, ovf=0, CTRL=0, RXDATA=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, lcd_dc=0.
REQ-038 A reset mid-frame SHALL abort the frame with no further SPI edges and SHALL discard FIFO contents.

Verification
REQ-039 Test: DIV=1, mode 0, push 0xA5 with DC=1. Required: cs low, 8 rising edges, each 4 clk apart; MOSI reads 1,0,1,0,0,1,0,1; lcd_dc=1; cs high after TRAIL.
REQ-040 Test: mode 3 (cpol=1, cpha=1), MISO loopback to MOSI, push 0x3C. Required: idle spi_clk=1; RXDATA reads 0x3C.
REQ-041 Test: push 3 words back-to-back. Required: spi_cs_n stays low across all 24 bits; busy=1 until the last TRAIL ends.
REQ-042 Test: FIFO_DEPTH=8, push 10 words while the SPI clock is stalled by a large div. Required: first word popped, level reaches 8, full=1, ovf=1; one STATUS read then ovf=0.
REQ-043 Test: reset_n low at bit 4 of a frame. Required: spi_cs_n=1 and spi_clk=0 immediately; FIFO empty; no edges after release until a new push.
REQ-044 Test: CTRL write of div=7 while busy. Required: ignored; CTRL readback unchanged; frame timing unchanged.
